cheat_loader: RTL and testbench
===============================

Name: cheat_loader

Overview:
- Upstream feeder for the cheat-code matcher. Receives a downloaded cheat file as a byte stream, assembles 16-byte records into the 129-bit code bus {strobe, flags, address, compare, replace}, and strobes each record into the matcher.
- Drives the matcher's clear input at the start of every new file.
- Sits between the download/ioctl path and the matcher.

Parameters:
- MAX_CODES, 32: matcher capacity. Records beyond this count are consumed and discarded.
- STROBE_CYCLES, 4: length in cycles of each of the setup, strobe-high and strobe-low phases. Minimum 2.
- CLEAR_CYCLES, 2: number of cycles codes_clear is asserted.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- dl_start  in  1  1-cycle pulse: new cheat file begins
- dl_done  in  1  1-cycle pulse: file finished
- dl_valid  in  1  byte valid
- dl_data  in  8  byte
- dl_ready  out  1  byte accepted when dl_valid & dl_ready
- code  out  129  bit 128 = strobe; bits 127:0 = record
- codes_clear  out  1  drives the matcher's reset input
- code_count  out  $clog2(MAX_CODES+1)  records delivered
- busy  out  1  state != IDLE
- overflow  out  1  sticky: a record was dropped because code_count == MAX_CODES
- err_partial  out  1  sticky: dl_done arrived with an incomplete record

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0; byte_cnt 0; record register 0; done_pend 0.
- States: IDLE, CLEAR, COLLECT, SETUP, HIGH, LOW.
- dl_start, any state, highest priority: next state CLEAR.
  - code <= 0; byte_cnt, code_count, overflow, err_partial, done_pend cleared.
  - A byte or dl_done in the same cycle is ignored.
- CLEAR: codes_clear = 1, dl_ready = 0 for exactly CLEAR_CYCLES cycles, then COLLECT.
- COLLECT: dl_ready = 1.
  - Accepted byte k (k = byte_cnt, 0..15) is written to record[127-8k -: 8]. Big-endian: first byte lands at bits 127:120. byte_cnt wraps 15 -> 0.
  - On the cycle the 16th byte is accepted:
    - If code_count < MAX_CODES: next state SETUP; code[127:0] <= assembled record; dl_ready drops the following cycle.
    - Else: overflow <= 1; stay in COLLECT; record discarded.
- SETUP: code[128] = 0 and code[127:0] stable for STROBE_CYCLES cycles, then HIGH.
- HIGH: code[128] = 1 for STROBE_CYCLES cycles. code_count increments on the first HIGH cycle.
- LOW: code[128] = 0 for STROBE_CYCLES cycles, code[127:0] still held, then COLLECT.
  - The strobe rises only after data has been stable for at least 2 cycles. The low gap guarantees a fresh rising edge per record.
- dl_done:
  - In COLLECT: handled that cycle.
  - In SETUP/HIGH/LOW: latched into done_pend and handled on the first COLLECT cycle.
  - In IDLE/CLEAR: ignored.
  - Handling: if byte_cnt != 0 (after any byte accepted in the same cycle), err_partial <= 1 and the partial record is discarded. Next state IDLE, dl_ready = 0.
  - dl_done coincident with the 16th byte: the record is delivered first (SETUP/HIGH/LOW), then IDLE; err_partial stays 0.
- Record-to-strobe latency: 16th byte accepted at cycle t; code[127:0] valid at t+1; code[128] high at t+1+STROBE_CYCLES.
- code[127:0] holds the last delivered record in IDLE/COLLECT.
- Reset mid-record: everything returns to reset values asynchronously; no strobe glitch (code[128] forced 0).

Optional Feature:
- CHEAT_LE_SWAP_EN
- Defined: byte order is reversed within each 32-bit word of the record, so a little-endian file yields the big-endian layout the matcher expects. Byte k goes to word (k>>2), byte lane (k&3) counted from the LSB.
- Undefined: pure big-endian placement as above.
- All timing is identical in both builds.

Test Plan:
- Reset, dl_start, then 16 bytes 00 00 00 01, 00 00 80 10, 00 00 00 AA, 00 00 00 55 -> codes_clear high exactly 2 cycles; code[127:0] = 0x00000001_00008010_000000AA_00000055; code[128] rises once, 4 cycles after data; code_count = 1.
- Three back-to-back records, dl_valid held high -> dl_ready low during each SETUP/HIGH/LOW; exactly 3 strobe rising edges; code_count = 3; no byte lost or duplicated.
- MAX_CODES = 2, send 3 records -> 2 strobes; overflow = 1; code_count = 2; third record fully consumed, dl_ready returns to 1.
- 20 bytes, then dl_done -> 1 record delivered; err_partial = 1; IDLE; dl_ready = 0.
- dl_done on the same cycle as the 16th byte -> record strobed; then IDLE; err_partial = 0. dl_done during HIGH -> held until LOW completes, then IDLE.
- reset_n low during HIGH -> code[128] = 0 immediately. dl_start during SETUP -> CLEAR; code_count = 0. With CHEAT_LE_SWAP_EN, bytes 01 00 00 00 ... -> code[127:96] = 0x00000001.

Source files
------------

// File: rtl/cheat_loader_if.sv
// cheat_loader_if: byte-stream download handshake between the ioctl path and the cheat loader
interface cheat_loader_if;
  logic       dl_start;
  logic       dl_done;
  logic       dl_valid;
  logic [7:0] dl_data;
  logic       dl_ready;
  modport master(output dl_start, dl_done, dl_valid, dl_data, input dl_ready);
  modport slave(input dl_start, dl_done, dl_valid, dl_data, output dl_ready);
endinterface

// File: rtl/cheat_loader.sv
// cheat_loader: assembles 16-byte cheat records and strobes them into the matcher.
// Define CHEAT_LE_SWAP_EN to reverse byte order within each 32-bit word.
module cheat_loader #(
  parameter int MAX_CODES = 32,
  parameter int STROBE_CYCLES = 4,
  parameter int CLEAR_CYCLES = 2,
  localparam int CCW = $clog2(MAX_CODES + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  cheat_loader_if.slave  dl,
  output logic [128:0]   code,
  output logic           codes_clear,
  output logic [CCW-1:0] code_count,
  output logic           busy,
  output logic           overflow,
  output logic           err_partial
);
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, COLLECT = 3'd2, SETUP = 3'd3, HIGH = 3'd4, LOW = 3'd5;
  localparam int PM = STROBE_CYCLES > CLEAR_CYCLES ? STROBE_CYCLES : CLEAR_CYCLES;
  localparam int PW = $clog2(PM);
  localparam logic [PW-1:0] S_END = PW'(STROBE_CYCLES - 1);
  localparam logic [PW-1:0] C_END = PW'(CLEAR_CYCLES - 1);
  logic [2:0]    state;
  logic [PW-1:0] cnt;
  logic [3:0]    bc, bc_nx;
  logic [127:0]  rec, rec_nx, rec_out;
  logic          done_pend, acc, last, done;
  logic [6:0]    lo;
`ifdef CHEAT_LE_SWAP_EN
  assign lo = {~bc[3:2], bc[1:0], 3'b000};
`else
  assign lo = {~bc, 3'b000};
`endif
  assign acc = state == COLLECT && dl.dl_valid;
  assign bc_nx = bc + {3'b000, acc};
  assign last = acc && bc == 4'd15;
  assign done = dl.dl_done | done_pend;
  assign dl.dl_ready = state == COLLECT;
  assign codes_clear = state == CLEAR;
  assign busy = state != IDLE;
  assign code = {state == HIGH, rec_out};
  always_comb begin
    rec_nx = rec;
    if (acc) rec_nx[lo +: 8] = dl.dl_data;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      bc <= '0;
      rec <= '0;
      rec_out <= '0;
      code_count <= '0;
      overflow <= 1'b0;
      err_partial <= 1'b0;
      done_pend <= 1'b0;
    end else if (dl.dl_start) begin
      state <= CLEAR;
      cnt <= '0;
      bc <= '0;
      rec <= '0;
      rec_out <= '0;
      code_count <= '0;
      overflow <= 1'b0;
      err_partial <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        CLEAR: begin
          cnt <= cnt == C_END ? '0 : cnt + 1'b1;
          if (cnt == C_END) state <= COLLECT;
        end
        COLLECT: begin
          rec <= rec_nx;
          bc <= bc_nx;
          done_pend <= 1'b0;
          if (last && code_count < CCW'(MAX_CODES)) begin
            state <= SETUP;
            rec_out <= rec_nx;
            done_pend <= dl.dl_done;
          end else begin
            if (last) overflow <= 1'b1;
            if (done) begin
              state <= IDLE;
              bc <= '0;
              if (bc_nx != 4'd0) err_partial <= 1'b1;
            end
          end
        end
        default: begin
          if (dl.dl_done) done_pend <= 1'b1;
          cnt <= cnt == S_END ? '0 : cnt + 1'b1;
          if (cnt == S_END) begin
            state <= state == SETUP ? HIGH : state == HIGH ? LOW : COLLECT;
            if (state == SETUP) code_count <= code_count + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cheat_loader.sv
// tb_cheat_loader: directed tests for cheat_loader (default build and MAX_CODES=2)
module tb_cheat_loader;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  logic sel = 1'b0, start = 1'b0, done = 1'b0, valid = 1'b0;
  logic [7:0] data = 8'h00;
  cheat_loader_if i0 ();
  cheat_loader_if i1 ();
  assign i0.dl_start = start & !sel;
  assign i0.dl_done = done & !sel;
  assign i0.dl_valid = valid & !sel;
  assign i0.dl_data = data;
  assign i1.dl_start = start & sel;
  assign i1.dl_done = done & sel;
  assign i1.dl_valid = valid & sel;
  assign i1.dl_data = data;
  logic [128:0] c0, c1;
  logic clr0, clr1, busy0, busy1, ovf0, ovf1, err0, err1;
  logic [5:0] cnt0;
  logic [1:0] cnt1;
  cheat_loader u0 (.clk(clk), .reset_n(reset_n), .dl(i0), .code(c0), .codes_clear(clr0),
                   .code_count(cnt0), .busy(busy0), .overflow(ovf0), .err_partial(err0));
  cheat_loader #(.MAX_CODES(2)) u1 (.clk(clk), .reset_n(reset_n), .dl(i1), .code(c1), .codes_clear(clr1),
                   .code_count(cnt1), .busy(busy1), .overflow(ovf1), .err_partial(err1));
  logic rdy, clr, busy, ovf, err;
  logic [128:0] code;
  int ccount;
  assign rdy = sel ? i1.dl_ready : i0.dl_ready;
  assign code = sel ? c1 : c0;
  assign clr = sel ? clr1 : clr0;
  assign busy = sel ? busy1 : busy0;
  assign ovf = sel ? ovf1 : ovf0;
  assign err = sel ? err1 : err0;
  assign ccount = sel ? 32'(cnt1) : 32'(cnt0);
`ifdef CHEAT_LE_SWAP_EN
  localparam logic [127:0] EXP1 = 128'h01000000_10800000_AA000000_55000000;
  localparam logic [127:0] RA = 128'h03020100_07060504_0B0A0908_0F0E0D0C;
  localparam logic [127:0] RB = 128'h13121110_17161514_1B1A1918_1F1E1D1C;
  localparam logic [127:0] RC = 128'h23222120_27262524_2B2A2928_2F2E2D2C;
  localparam logic [127:0] RLE = 128'h00000001_00000000_00000000_00000000;
`else
  localparam logic [127:0] EXP1 = 128'h00000001_00008010_000000AA_00000055;
  localparam logic [127:0] RA = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] RB = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] RC = 128'h202122232425262728292A2B2C2D2E2F;
  localparam logic [127:0] RLE = 128'h01000000_00000000_00000000_00000000;
`endif
  int rises = 0, bad = 0, tests = 0, fails = 0;
  logic prev = 1'b0;
  logic [127:0] cap [8];
  always @(negedge clk) begin
    if (code[128] && !prev) begin
      cap[rises % 8] = code[127:0];
      rises++;
    end
    prev = code[128];
    if (code[128] && rdy) bad++;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_ready(input int lim);
    int n = 0;
    while (!rdy && n < lim) begin
      tick();
      n++;
    end
    if (!rdy) begin
      tests++;
      fails++;
      $display("FAIL wait_ready: timeout, dl_ready=%b required 1", rdy);
    end
  endtask
  task automatic wait_strobe(input int lim);
    int n = 0;
    while (!code[128] && n < lim) begin
      tick();
      n++;
    end
    if (!code[128]) begin
      tests++;
      fails++;
      $display("FAIL wait_strobe: timeout, strobe=%b required 1", code[128]);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    valid = 1'b1;
    data = b;
    wait_ready(40);
    tick();
  endtask
  task automatic send_seq(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i));
  endtask
  task automatic start_file;
    pulse_start();
    wait_ready(10);
  endtask
  task automatic test_reset;
    reset_n = 1'b0;
    tick();
    tick();
    tests++; if (c0 !== 129'd0) begin fails++; $display("FAIL reset_code: got %h want 0", c0); end
    tests++; if (c1 !== 129'd0) begin fails++; $display("FAIL reset_code1: got %h want 0", c1); end
    tests++; if ({clr0, busy0, ovf0, err0, i0.dl_ready} !== 5'b0) begin fails++; $display("FAIL reset_flags: got %b want 00000", {clr0, busy0, ovf0, err0, i0.dl_ready}); end
    tests++; if (cnt0 !== 6'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", cnt0); end
    reset_n = 1'b1;
    tick();
  endtask
  task automatic test_basic;
    logic [7:0] v [16] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h80, 8'h10,
                          8'h00, 8'h00, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h55};
    int n = 0, r0 = rises, k = 0;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      if (clr) n++;
      tick();
    end
    tests++; if (n !== 2) begin fails++; $display("FAIL clear_len: got %0d want 2", n); end
    for (int i = 0; i < 16; i++) send_byte(v[i]);
    valid = 1'b0;
    tests++; if (code !== {1'b0, EXP1}) begin fails++; $display("FAIL basic_data: got %h want %h", code, {1'b0, EXP1}); end
    tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL basic_ready_drop: got %b want 0", rdy); end
    while (!code[128] && k < 20) begin
      tick();
      k++;
    end
    tests++; if (k !== 4) begin fails++; $display("FAIL strobe_latency: got %0d want 4", k); end
    wait_ready(20);
    tests++; if (rises - r0 !== 1) begin fails++; $display("FAIL basic_strobes: got %0d want 1", rises - r0); end
    tests++; if (ccount !== 1) begin fails++; $display("FAIL basic_count: got %0d want 1", ccount); end
    tests++; if (code[127:0] !== EXP1) begin fails++; $display("FAIL basic_hold: got %h want %h", code[127:0], EXP1); end
  endtask
  task automatic test_back_to_back;
    int r0 = rises;
    start_file();
    send_seq(8'h00, 16);
    send_seq(8'h10, 16);
    send_seq(8'h20, 16);
    valid = 1'b0;
    wait_ready(30);
    tests++; if (rises - r0 !== 3) begin fails++; $display("FAIL b2b_strobes: got %0d want 3", rises - r0); end
    tests++; if (cap[r0 % 8] !== RA) begin fails++; $display("FAIL b2b_rec0: got %h want %h", cap[r0 % 8], RA); end
    tests++; if (cap[(r0 + 1) % 8] !== RB) begin fails++; $display("FAIL b2b_rec1: got %h want %h", cap[(r0 + 1) % 8], RB); end
    tests++; if (cap[(r0 + 2) % 8] !== RC) begin fails++; $display("FAIL b2b_rec2: got %h want %h", cap[(r0 + 2) % 8], RC); end
    tests++; if (ccount !== 3) begin fails++; $display("FAIL b2b_count: got %0d want 3", ccount); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL b2b_ready_in_strobe: got %0d want 0", bad); end
  endtask
  task automatic test_overflow;
    int r0;
    sel = 1'b1;
    r0 = rises;
    start_file();
    send_seq(8'h00, 48);
    valid = 1'b0;
    tests++; if (rises - r0 !== 2) begin fails++; $display("FAIL ovf_strobes: got %0d want 2", rises - r0); end
    tests++; if (cap[(r0 + 1) % 8] !== RB) begin fails++; $display("FAIL ovf_rec1: got %h want %h", cap[(r0 + 1) % 8], RB); end
    tests++; if ({ovf, err, rdy, busy} !== 4'b1011) begin fails++; $display("FAIL ovf_flags: got %b want 1011", {ovf, err, rdy, busy}); end
    tests++; if (ccount !== 2) begin fails++; $display("FAIL ovf_count: got %0d want 2", ccount); end
    sel = 1'b0;
  endtask
  task automatic test_partial;
    int r0 = rises;
    start_file();
    send_seq(8'h00, 20);
    valid = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    tests++; if ({err, busy, rdy} !== 3'b100) begin fails++; $display("FAIL partial_flags: got %b want 100", {err, busy, rdy}); end
    tests++; if (rises - r0 !== 1) begin fails++; $display("FAIL partial_strobes: got %0d want 1", rises - r0); end
    tests++; if (ccount !== 1) begin fails++; $display("FAIL partial_count: got %0d want 1", ccount); end
    tests++; if (cap[r0 % 8] !== RA) begin fails++; $display("FAIL partial_rec: got %h want %h", cap[r0 % 8], RA); end
  endtask
  task automatic test_done_coincident;
    int r0 = rises, n = 0;
    start_file();
    send_seq(8'h00, 15);
    done = 1'b1;
    send_byte(8'h0F);
    done = 1'b0;
    valid = 1'b0;
    tests++; if ({busy, code[127:0]} !== {1'b1, RA}) begin fails++; $display("FAIL coinc_setup: got %b/%h want 1/%h", busy, code[127:0], RA); end
    while (busy && n < 40) begin
      tick();
      n++;
    end
    tests++; if (n !== 13) begin fails++; $display("FAIL coinc_idle_after: got %0d want 13", n); end
    tests++; if (rises - r0 !== 1) begin fails++; $display("FAIL coinc_strobes: got %0d want 1", rises - r0); end
    tests++; if ({err, rdy} !== 2'b00) begin fails++; $display("FAIL coinc_flags: got %b want 00", {err, rdy}); end
  endtask
  task automatic test_done_high;
    int r0 = rises, n = 0;
    start_file();
    send_seq(8'h10, 16);
    valid = 1'b0;
    wait_strobe(20);
    done = 1'b1;
    tick();
    done = 1'b0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    tests++; if (n !== 8) begin fails++; $display("FAIL high_done_delay: got %0d want 8", n); end
    tests++; if ({err, rdy, busy} !== 3'b000) begin fails++; $display("FAIL high_done_flags: got %b want 000", {err, rdy, busy}); end
    tests++; if (rises - r0 !== 1) begin fails++; $display("FAIL high_done_strobes: got %0d want 1", rises - r0); end
    tests++; if (cap[r0 % 8] !== RB) begin fails++; $display("FAIL high_done_rec: got %h want %h", cap[r0 % 8], RB); end
  endtask
  task automatic test_reset_high;
    start_file();
    send_seq(8'h00, 16);
    valid = 1'b0;
    wait_strobe(20);
    reset_n = 1'b0;
    #1;
    tests++; if (code !== 129'd0) begin fails++; $display("FAIL reset_high_code: got %h want 0", code); end
    tests++; if ({ccount[0], busy} !== 2'b00) begin fails++; $display("FAIL reset_high_state: got %b want 00", {ccount[0], busy}); end
    #3;
    reset_n = 1'b1;
    tick();
  endtask
  task automatic test_start_setup;
    int r1;
    start_file();
    send_seq(8'h00, 16);
    valid = 1'b0;
    wait_ready(30);
    tests++; if (ccount !== 1) begin fails++; $display("FAIL ss_count_before: got %0d want 1", ccount); end
    r1 = rises;
    send_seq(8'h10, 16);
    valid = 1'b0;
    pulse_start();
    tests++; if ({clr, rdy, busy} !== 3'b101) begin fails++; $display("FAIL ss_clear: got %b want 101", {clr, rdy, busy}); end
    tests++; if (code !== 129'd0 || ccount !== 0) begin fails++; $display("FAIL ss_cleared: got %h/%0d want 0/0", code, ccount); end
    wait_ready(10);
    tests++; if (rises - r1 !== 0) begin fails++; $display("FAIL ss_no_strobe: got %0d want 0", rises - r1); end
  endtask
  task automatic test_le;
    start_file();
    for (int i = 0; i < 16; i++) send_byte(i == 0 ? 8'h01 : 8'h00);
    valid = 1'b0;
    tests++; if (code[127:0] !== RLE) begin fails++; $display("FAIL byte_order: got %h want %h", code[127:0], RLE); end
    wait_ready(30);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_partial();
    test_done_coincident();
    test_done_high();
    test_reset_high();
    test_start_setup();
    test_le();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
